mux_channel_scanner: RTL

Sequential select generator and sample collector driving the 16:1 two-level mux (4:1 group stage + 4:1 final stage). Steps the mux selects through all 16 channels, waits a programmable settle time per channel, samples the mux output, and assembles a 16-bit snapshot. The snapshot goes downstream over a valid/ready handshake. Sits directly upstream (selects) and downstream (output capture) of the mux.

---
 rtl/mux_channel_scanner.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mux_channel_scanner.sv
// Steps a 16:1 two-level mux through all channels, samples each after a settle
// window and presents the 16-bit snapshot on a valid/ready port. Optional parity: MUX_SCAN_PARITY_EN.
module mux_channel_scanner #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cont,
    input  logic        mux_out,
    output logic [1:0]  sel_lo,
    output logic [1:0]  sel_hi,
    output logic        busy,
    output logic [15:0] data,
    output logic        valid,
    input  logic        ready
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic        parity
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  ch_q, ch_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] shift_q, shift_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;
`ifdef MUX_SCAN_PARITY_EN
    logic        parity_q, parity_d;
`endif

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
`ifdef MUX_SCAN_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                ch_d = '0;
                if (start) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                shift_d[ch_q] = mux_out;
                if (ch_q != 4'd15) begin
                    ch_d    = ch_q + 4'd1;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else begin
                    // publish from shift_d so the channel-15 bit lands in this snapshot
                    data_d  = shift_d;
                    valid_d = 1'b1;
                    ch_d    = '0;
                    state_d = DONE;
`ifdef MUX_SCAN_PARITY_EN
                    parity_d = ^shift_d;
`endif
                end
            end
            DONE: begin
                if (ready) begin
                    valid_d = 1'b0;
                    if (cont) begin
                        state_d = SETTLE;
                        ch_d    = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
`ifdef MUX_SCAN_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign sel_lo = ch_q[1:0];
    assign sel_hi = ch_q[3:2];
    assign busy   = (state_q == SETTLE) || (state_q == SAMPLE);
    assign data   = data_q;
    assign valid  = valid_q;
`ifdef MUX_SCAN_PARITY_EN
    assign parity = parity_q;
`endif

endmodule
